// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches over a req/ready + rvalid handshake, presents the
// instruction to the control unit and computes the next PC once it is acknowledged.
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [31:0] o_pc,
  input  logic        i_inst_ack,
  input  logic        i_halt,
  input  logic        i_trap,
  input  logic        i_jump_sel,
  input  logic        i_jump_type_sel,
  input  logic        i_branch_taken,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_target,
  output logic        o_halted,
  output logic        o_trapped,
  output logic [31:0] o_retire_cnt
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StHalt, StTrap} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] retire_q, retire_d;
  logic [31:0] next_pc;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_ADDR;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      retire_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      retire_q  <= retire_d;
    end
  end

  always_comb begin
    if (i_jump_sel && i_jump_type_sel) begin
      next_pc = i_target & ~32'h1;
    end else if (i_jump_sel || i_branch_taken) begin
      next_pc = pc_q + i_imm;
    end else begin
      next_pc = pc_q + 32'd4;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    retire_d     = retire_q;
    o_imem_req   = 1'b0;
    o_inst_valid = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) state_d = StWait;
      end
      StWait: begin
        if (i_imem_rvalid) begin
          inst_d    = i_imem_rdata;
          inst_pc_d = pc_q;
          state_d   = StHold;
        end
      end
      StHold: begin
        o_inst_valid = 1'b1;
        if (i_inst_ack) begin
          retire_d = retire_q + 32'd1;
          if (i_halt) begin
            state_d = StHalt;
          end else if (i_trap || next_pc[1]) begin
            // Misaligned target traps and leaves the PC on the offending instruction
            state_d = StTrap;
          end else begin
            pc_d    = next_pc & ~32'h3;
            state_d = StReq;
          end
        end
      end
      StHalt, StTrap: ;
      default: state_d = StIdle;
    endcase
  end

  assign o_imem_addr  = pc_q & ~32'h3;
  assign o_inst       = inst_q;
  assign o_opcode     = inst_q[6:0];
  assign o_funct3     = inst_q[14:12];
  assign o_funct7     = inst_q[31:25];
  assign o_pc         = inst_pc_q;
  assign o_halted     = (state_q == StHalt);
  assign o_trapped    = (state_q == StTrap);
  assign o_retire_cnt = retire_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a PC/retire reference model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0, rvalid = 1'b0, ack = 1'b0;
  logic        halt = 1'b0, trap = 1'b0, jsel = 1'b0, jtype = 1'b0, btaken = 1'b0;
  logic [31:0] rdata = 32'h0, imm = 32'h0, target = 32'h0;
  logic        o_imem_req, o_inst_valid, o_halted, o_trapped;
  logic [31:0] o_imem_addr, o_inst, o_pc, o_retire_cnt;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_retire;
  bit          m_halted, m_trapped;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_ADDR(RST_PC)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ready(ready), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_opcode(o_opcode),
    .o_funct3(o_funct3), .o_funct7(o_funct7), .o_pc(o_pc),
    .i_inst_ack(ack), .i_halt(halt), .i_trap(trap), .i_jump_sel(jsel),
    .i_jump_type_sel(jtype), .i_branch_taken(btaken), .i_imm(imm), .i_target(target),
    .o_halted(o_halted), .o_trapped(o_trapped), .o_retire_cnt(o_retire_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ready = 0; rvalid = 0; ack = 0; halt = 0; trap = 0;
    jsel = 0; jtype = 0; btaken = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RST_PC; m_retire = 0; m_halted = 0; m_trapped = 0;
  endtask

  // One complete fetch/decode/ack of `word` with the given control-unit response.
  task automatic run_instr(input logic [31:0] word, input logic h, t, js, jt, bt,
                           input logic [31:0] im, tg);
    int n;
    logic [31:0] nxt;
    n = 0;
    while (!o_imem_req && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!o_imem_req) begin
      failures++; $display("FAIL req_timeout: req=%0b required 1", o_imem_req); return;
    end
    checks++;
    if (o_imem_addr !== m_pc) begin
      failures++; $display("FAIL fetch_addr: got %h required %h", o_imem_addr, m_pc);
    end
    // Stale rvalid while REQ waits for ready must be ignored
    repeat ($urandom_range(0, 2)) begin
      rvalid = 1; rdata = $urandom; @(negedge clk);
    end
    rvalid = 0;
    ready = 1; @(negedge clk); ready = 0;
    checks++;
    if (o_imem_req !== 1'b0) begin
      failures++; $display("FAIL req_in_wait: got %b required 0", o_imem_req);
    end
    // Acks outside HOLD must be ignored
    repeat ($urandom_range(0, 2)) begin
      ack = $urandom_range(0, 1); halt = 1; @(negedge clk);
    end
    ack = 0; halt = 0;
    rdata = word; rvalid = 1; @(negedge clk); rvalid = 0; rdata = $urandom;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    checks++;
    if (o_inst_valid !== 1'b1 || o_inst !== word || o_pc !== m_pc) begin
      failures++;
      $display("FAIL hold_inst: valid=%b inst=%h pc=%h required 1 %h %h",
               o_inst_valid, o_inst, o_pc, word, m_pc);
    end
    checks++;
    if (o_opcode !== word[6:0] || o_funct3 !== word[14:12] || o_funct7 !== word[31:25]) begin
      failures++;
      $display("FAIL fields: op=%h f3=%h f7=%h required %h %h %h", o_opcode, o_funct3,
               o_funct7, word[6:0], word[14:12], word[31:25]);
    end
    halt = h; trap = t; jsel = js; jtype = jt; btaken = bt; imm = im; target = tg; ack = 1;
    @(negedge clk);
    ack = 0; halt = 0; trap = 0; jsel = 0; jtype = 0; btaken = 0;
    m_retire++;
    if (h) m_halted = 1;
    else if (t) m_trapped = 1;
    else begin
      if (js && jt) nxt = {tg[31:1], 1'b0};
      else if (js || bt) nxt = m_pc + im;
      else nxt = m_pc + 32'd4;
      if (nxt[1]) m_trapped = 1;
      else m_pc = nxt;
    end
    checks++;
    if (o_retire_cnt !== m_retire || o_halted !== m_halted || o_trapped !== m_trapped) begin
      failures++;
      $display("FAIL after_ack: retire=%0d halted=%b trapped=%b required %0d %b %b",
               o_retire_cnt, o_halted, o_trapped, m_retire, m_halted, m_trapped);
    end
    checks++;
    if (m_halted || m_trapped) begin
      if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL terminal_quiet: req=%b valid=%b required 0 0", o_imem_req, o_inst_valid);
      end
    end else if (o_imem_req !== 1'b1 || o_imem_addr !== m_pc) begin
      failures++;
      $display("FAIL next_addr: req=%b addr=%h required 1 %h", o_imem_req, o_imem_addr, m_pc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (o_imem_req !== 0 || o_inst_valid !== 0 || o_halted !== 0 || o_trapped !== 0 ||
        o_retire_cnt !== 0 || o_inst !== 0 || o_imem_addr !== RST_PC) begin
      failures++;
      $display("FAIL reset_state: req=%b v=%b h=%b t=%b cnt=%0d inst=%h addr=%h required zeros",
               o_imem_req, o_inst_valid, o_halted, o_trapped, o_retire_cnt, o_inst, o_imem_addr);
    end
    do_reset();
    #1;
    checks++;
    if (o_imem_req !== 0) begin
      failures++; $display("FAIL idle_no_req: got %b required 0", o_imem_req);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) run_instr($urandom, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (o_retire_cnt !== 32'd3 || o_imem_addr !== 32'hC) begin
      failures++;
      $display("FAIL seq_three: cnt=%0d addr=%h required 3 0000000c", o_retire_cnt, o_imem_addr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    run_instr($urandom, 0, 0, 0, 0, 0, 0, 0);
    run_instr($urandom, 0, 0, 0, 0, 0, 0, 0);
    run_instr($urandom, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, $urandom);
    checks++;
    if (o_imem_addr !== 32'h0) begin
      failures++; $display("FAIL branch_back: addr=%h required 00000000", o_imem_addr);
    end
  endtask

  task automatic test_jalr();
    do_reset();
    run_instr($urandom, 0, 0, 1, 1, 0, $urandom, 32'h101);
    checks++;
    if (o_imem_addr !== 32'h100) begin
      failures++; $display("FAIL jalr_target: addr=%h required 00000100", o_imem_addr);
    end
    run_instr($urandom, 0, 0, 1, 1, 0, $urandom, 32'h102);
    repeat (5) @(negedge clk);
    checks++;
    if (o_trapped !== 1 || o_imem_req !== 0) begin
      failures++; $display("FAIL jalr_misaligned: trapped=%b req=%b required 1 0",
                           o_trapped, o_imem_req);
    end
  endtask

  task automatic test_halt();
    do_reset();
    run_instr($urandom, 0, 0, 0, 0, 0, 0, 0);
    run_instr($urandom, 1, 0, 0, 0, 0, 0, 0);
    ack = 1;
    repeat (8) @(negedge clk);
    ack = 0;
    checks++;
    if (o_halted !== 1 || o_imem_req !== 0 || o_retire_cnt !== 32'd2) begin
      failures++; $display("FAIL halt_sticky: halted=%b req=%b cnt=%0d required 1 0 2",
                           o_halted, o_imem_req, o_retire_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr($urandom, 0, 0, 1, 1, 0, 0, 32'hFFFF_FFFC);
    run_instr($urandom, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (o_imem_addr !== 32'h0) begin
      failures++; $display("FAIL pc_wrap: addr=%h required 00000000", o_imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] word;
    do_reset();
    while (!o_imem_req) @(negedge clk);
    ready = 1; @(negedge clk); ready = 0;
    rst_n = 0; #1;
    checks++;
    if (o_imem_req !== 0 || o_inst_valid !== 0) begin
      failures++; $display("FAIL reset_in_wait: req=%b valid=%b required 0 0",
                           o_imem_req, o_inst_valid);
    end
    @(negedge clk);
    rst_n = 1; rvalid = 1; rdata = 32'hDEAD_BEEF;
    m_pc = RST_PC; m_retire = 0; m_halted = 0; m_trapped = 0;
    @(negedge clk);
    checks++;
    if (o_imem_req !== 1 || o_imem_addr !== RST_PC || o_inst_valid !== 0) begin
      failures++; $display("FAIL stale_rvalid: req=%b addr=%h valid=%b required 1 %h 0",
                           o_imem_req, o_imem_addr, o_inst_valid, RST_PC);
    end
    @(negedge clk);
    rvalid = 0;
    word = 32'h1234_5678;
    run_instr(word, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      run_instr($urandom, r < 4, r >= 4 && r < 8, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom & 32'hFFFF_FFFE, $urandom);
      if (m_halted || m_trapped) do_reset();
    end
  endtask

  initial begin
    m_pc = RST_PC; m_retire = 0; m_halted = 0; m_trapped = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
